sparc_ifu_sscan_ser: RTL and testbench



---
 rtl/sparc_ifu_sscan_ser.sv | 59 +++++
 tb/tb_sparc_ifu_sscan_ser.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_sscan_ser.sv
// sparc_ifu_sscan_ser: serializes a frozen IFU shadow-scan snapshot (plus even parity) onto sscan_so
module sparc_ifu_sscan_ser #(
  parameter int WIDTH  = 94,
  parameter int PAR_EN = 1
) (
  input  logic             rclk,
  input  logic             rst_l,
  input  logic             snap_vld,
  input  logic [WIDTH-1:0] snap_data,
  input  logic             shift_en,
  input  logic             clr_drop,
  output logic             sscan_so,
  output logic             busy,
  output logic             frame_done,
  output logic             snap_drop
);
  localparam int FLEN = WIDTH + ((PAR_EN != 0) ? 1 : 0);
  localparam int CW   = $clog2(FLEN);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q, state_d;
  logic [FLEN-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            so_q, so_d, done_q, done_d, drop_q, drop_d;
  logic            load, shift, last;
  // next-state: load on an idle request, shift on enable, leave after the final frame bit
  always_comb begin
    load    = (state_q == IDLE) && snap_vld;
    shift   = (state_q == SHIFT) && shift_en;
    last    = shift && (cnt_q == CW'(FLEN - 1));
    state_d = load ? SHIFT : last ? IDLE : state_q;
    shreg_d = load ? FLEN'({(PAR_EN != 0) && (^snap_data), snap_data}) : shift ? shreg_q >> 1 : shreg_q;
    cnt_d   = (load || last) ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    so_d    = (state_d == SHIFT) && shreg_d[0];
    done_d  = last;
    drop_d  = (snap_vld && (state_q == SHIFT)) || (drop_q && !clr_drop);
  end
  // state and registered outputs; reset abandons any frame in flight
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end
  assign sscan_so   = so_q;
  assign busy       = (state_q == SHIFT);
  assign frame_done = done_q;
  assign snap_drop  = drop_q;
endmodule

// File: tb/tb_sparc_ifu_sscan_ser.sv
// tb_sparc_ifu_sscan_ser: directed checks of the shadow-scan serializer with and without parity
module tb_sparc_ifu_sscan_ser;
  logic        rclk = 1'b0;
  logic        rst_l, snap_vld, snap_vld2, shift_en, clr_drop;
  logic [93:0] snap_data;
  logic        sscan_so, busy, frame_done, snap_drop;
  logic        so2, busy2, done2, drop2;
  int          checks = 0;
  int          errors = 0;
  logic        exp_drop = 1'b0;
  localparam logic [93:0] D4 = 94'h0123_4567_89AB_CDEF_0123;
  localparam logic [93:0] D5 = 94'h3FFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [93:0] D6 = 94'h4_0000_0000_0000;
  localparam logic [93:0] D3 = {47{2'b10}};

  always #5 rclk = ~rclk;

  sparc_ifu_sscan_ser dut (
    .rclk(rclk), .rst_l(rst_l), .snap_vld(snap_vld), .snap_data(snap_data),
    .shift_en(shift_en), .sscan_so(sscan_so), .busy(busy), .frame_done(frame_done),
    .snap_drop(snap_drop), .clr_drop(clr_drop)
  );

  sparc_ifu_sscan_ser #(.WIDTH(94), .PAR_EN(0)) dut2 (
    .rclk(rclk), .rst_l(rst_l), .snap_vld(snap_vld2), .snap_data(snap_data),
    .shift_en(shift_en), .sscan_so(so2), .busy(busy2), .frame_done(done2),
    .snap_drop(drop2), .clr_drop(clr_drop)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge rclk);
    #1;
  endtask

  task automatic set_vld(input logic v);
    snap_vld  = v;
    snap_vld2 = v;
  endtask

  // Called right after the load edge; leaves the bench on the frame_done cycle.
  task automatic run_frame(input string nm, input logic [94:0] exp, input int vld_at, input int clr_at, input int both_at);
    shift_en = 1'b1;
    for (int k = 0; k < 95; k++) begin
      snap_vld  = (k == vld_at) || (k == both_at);
      snap_vld2 = snap_vld && (k < 94);
      clr_drop  = (k == clr_at) || (k == both_at);
      chk($sformatf("%s so bit%0d", nm, k), sscan_so, exp[k]);
      chk($sformatf("%s busy bit%0d", nm, k), busy, 1'b1);
      chk($sformatf("%s done bit%0d", nm, k), frame_done, 1'b0);
      chk($sformatf("%s drop bit%0d", nm, k), snap_drop, exp_drop);
      if (k < 94) chk($sformatf("%s nopar so bit%0d", nm, k), so2, exp[k]);
      else chk($sformatf("%s nopar done early", nm), done2, 1'b1);
      step;
      if (snap_vld) exp_drop = 1'b1;
      else if (clr_drop) exp_drop = 1'b0;
      set_vld(1'b0);
      clr_drop = 1'b0;
    end
    chk({nm, " done pulse"}, frame_done, 1'b1);
    chk({nm, " busy end"}, busy, 1'b0);
    chk({nm, " so end"}, sscan_so, 1'b0);
    chk({nm, " drop end"}, snap_drop, exp_drop);
  endtask

  initial begin
    rst_l = 1'b0; set_vld(1'b0); shift_en = 1'b0; clr_drop = 1'b0; snap_data = '0;
    step; step;
    chk("rst so", sscan_so, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", frame_done, 1'b0);
    chk("rst drop", snap_drop, 1'b0);
    rst_l = 1'b1;
    // single one: data bit 0 then parity 1
    snap_data = 94'h1; shift_en = 1'b1; set_vld(1'b1);
    step; set_vld(1'b0);
    run_frame("t1", {1'b1, 94'h1}, -1, -1, -1);
    step;
    chk("t1 done one cycle", frame_done, 1'b0);
    // even weight: parity 0
    snap_data = 94'h3; set_vld(1'b1);
    step; set_vld(1'b0);
    run_frame("t2", {1'b0, 94'h3}, -1, -1, -1);
    step;
    chk("t2 done one cycle", frame_done, 1'b0);
    // shift_en toggling: every bit held across the disabled cycle
    snap_data = D3; set_vld(1'b1);
    step; set_vld(1'b0);
    for (int k = 0; k < 95; k++) begin
      shift_en = 1'b0;
      chk($sformatf("t3 so bit%0d", k), sscan_so, (k == 94) ? 1'b1 : D3[k]);
      chk($sformatf("t3 busy bit%0d", k), busy, 1'b1);
      step;
      chk($sformatf("t3 hold bit%0d", k), sscan_so, (k == 94) ? 1'b1 : D3[k]);
      chk($sformatf("t3 done hold%0d", k), frame_done, 1'b0);
      shift_en = 1'b1;
      step;
    end
    chk("t3 done pulse", frame_done, 1'b1);
    chk("t3 busy end", busy, 1'b0);
    step;
    chk("t3 done one cycle", frame_done, 1'b0);
    // requests while busy are dropped; clear alone clears, clear with request keeps set
    snap_data = D4; set_vld(1'b1);
    step; set_vld(1'b0);
    run_frame("t4", {^D4, D4}, 40, 60, 70);
    clr_drop = 1'b1;
    step; clr_drop = 1'b0; exp_drop = 1'b0;
    chk("t4 clr drop", snap_drop, 1'b0);
    chk("t4 done one cycle", frame_done, 1'b0);
    // request on the final shift edge is dropped, not loaded
    snap_data = 94'h2; set_vld(1'b1);
    step; set_vld(1'b0);
    run_frame("t4b", {1'b1, 94'h2}, 94, -1, -1);
    // request on the frame_done cycle is accepted
    snap_data = D5; set_vld(1'b1);
    step; set_vld(1'b0);
    chk("t5 busy after reload", busy, 1'b1);
    run_frame("t5", {1'b0, D5}, -1, -1, -1);
    step;
    chk("t5 idle busy", busy, 1'b0);
    chk("t5 done one cycle", frame_done, 1'b0);
    // reset mid-frame at bit 50
    snap_data = D6; set_vld(1'b1);
    step; set_vld(1'b0);
    for (int k = 0; k < 50; k++) begin
      if (k == 10) set_vld(1'b1);
      chk($sformatf("t6 so bit%0d", k), sscan_so, D6[k]);
      step;
      set_vld(1'b0);
    end
    chk("t6 so bit50", sscan_so, 1'b1);
    chk("t6 drop before rst", snap_drop, 1'b1);
    rst_l = 1'b0;
    step; rst_l = 1'b1; exp_drop = 1'b0;
    chk("t6 rst so", sscan_so, 1'b0);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst drop", snap_drop, 1'b0);
    chk("t6 rst done", frame_done, 1'b0);
    step;
    chk("t6 idle shift so", sscan_so, 1'b0);
    chk("t6 idle shift busy", busy, 1'b0);
    snap_data = 94'h5; set_vld(1'b1);
    step; set_vld(1'b0);
    run_frame("t6f", {1'b0, 94'h5}, -1, -1, -1);
    step;
    chk("t6f done one cycle", frame_done, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
